mips_cpu_fetch_ctrl: RTL and testbench
======================================

# mips_cpu_fetch_ctrl

Instruction-fetch sequencer for the MIPS CPU. It owns the architectural PC/NPC pair and drives the instruction-memory read port with a wait-request handshake. It presents each fetched instruction to decode for exactly one commit cycle, applies branch/jump redirects with MIPS delay-slot semantics, and halts the core when control transfers to address 0. It sits between the instruction bus and decode; the register file and ALU see only `instr_out` / `instr_valid`.

## Interface
- `RESET_VECTOR`, default 32'hBFC0_0000: first fetch address after reset.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `instr_read` output 1: read request to instruction memory.
- `instr_address` output 32: byte address of the fetch; always equals `pc_out`.
- `instr_waitrequest` input 1: memory not ready; request and address must be held.
- `instr_readdata` input 32: instruction word, valid when `instr_read && !instr_waitrequest`.
- `stall` input 1: back-end busy (e.g. data-memory access); blocks commit.
- `redirect_valid` input 1: the instruction being committed is a taken branch or jump.
- `redirect_target` input 32: destination address, sampled with `redirect_valid`.
- `instr_out` output 32: latched instruction for decode.
- `instr_valid` output 1: `instr_out` is valid; commit occurs when `instr_valid && !stall`.
- `pc_out` output 32: address of the instruction in `instr_out` / being fetched.
- `active` output 1: core running; low in reset, IDLE and HALT.
- `fetch_err` output 1: sticky; a redirect target was not word-aligned.

## Operation
- States: IDLE, FETCH, EXEC, HALT.
- IDLE: entered on reset; moves unconditionally to FETCH on the next clock.
- FETCH: `instr_read`=1. Stay while `instr_waitrequest`=1. On the accepting edge: latch `instr_readdata` into `instr_out`, then go to EXEC.
- EXEC: `instr_valid`=1. Stay while `stall`=1; no register changes in that case.
- On commit (EXEC && !stall):
  - `pc` <= `npc`.
  - `npc` <= `redirect_valid` ? `redirect_target` : `npc`+4.
  - Next state is FETCH, or HALT if the new `pc` equals 0.
- The pc/npc pair gives exactly one delay slot. The instruction after a taken branch always executes before the target.
- Misaligned target: a commit with `redirect_valid`=1 and `redirect_target[1:0]`≠0 sets `fetch_err` and forces HALT after the delay slot commits. The target is never fetched.
- Redirect in the delay slot (branch in delay slot): the new target overwrites `npc`, per the update rule above. No special case.
- HALT: terminal until reset. `instr_read`=0, `instr_valid`=0, `active`=0. `pc_out` holds 0 (or the delay-slot PC after `fetch_err`).
- Arithmetic: `npc`+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, which then halts.

## Timing
- Reset values:
  - state=IDLE, `pc`=`RESET_VECTOR`, `npc`=`RESET_VECTOR`+4.
  - `instr_out`=0, `instr_valid`=0, `instr_read`=0, `active`=0, `fetch_err`=0.
- `active` rises in the first FETCH cycle and stays high until HALT.
- Fetch latency: with `waitrequest`=0 and `stall`=0, one instruction commits every 2 cycles (FETCH, EXEC). Each wait cycle adds one.
- `instr_read` and `instr_address` stay stable from FETCH entry until acceptance. `instr_read` never drops while `waitrequest`=1.
- `redirect_valid`, `redirect_target` and `stall` are sampled only in EXEC; they are ignored in the other states.
- Reset mid-fetch (`rst_n` low during FETCH with `waitrequest`=1): `instr_read` drops asynchronously, and the restart fetches `RESET_VECTOR`.
- All outputs are registered or decoded from state only; there is no combinational input-to-output path.

## Structure
- Shared package `mips_cpu_pkg`:
  - `fetch_state_t` enum.
  - `RESET_VECTOR_DEFAULT`.
  - `HALT_ADDR` (32'h0).
- Sub-module `mips_cpu_fetch_pcreg`: the pc/npc register pair with enable, redirect mux and reset vector. The FSM stays in the top module.

## Test plan
- Reset release, `waitrequest`=0, no stall: `instr_address` = BFC00000, BFC00004, BFC00008 on cycles 1, 3, 5. `active` goes to 1 at cycle 1.
- `waitrequest` held 3 cycles on the first fetch: `instr_read`=1 and `address`=BFC00000 are stable for 4 cycles. `instr_valid` rises the cycle after acceptance.
- Taken branch at BFC00008 with target BFC00100: next fetches are BFC0000C (delay slot) then BFC00100.
- `stall`=1 for 5 cycles in EXEC: `instr_out`/`pc_out` are unchanged and there is no fetch. Resume gives exactly one commit.
- `jr` to 0 committed at BFC00010: delay slot BFC00014 is fetched and committed, then HALT. `active`=0 and `instr_read` stays 0 for 20 cycles.
- Redirect target 32'hBFC00102: `fetch_err`=1 and HALT after the delay slot. Asserting `rst_n` low mid-fetch then releasing restarts at BFC00000 with `fetch_err`=0.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared definitions for the MIPS CPU instruction-fetch path:
// sequencer state encoding, reset vector and halt address.
package mips_cpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
   localparam logic [31:0] HALT_ADDR            = 32'h0000_0000;
   localparam logic [31:0] INSTR_BYTES          = 32'd4;

   // True when an address can hold an instruction (low two bits clear).
   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/mips_cpu_fetch_pcreg.sv
// Architectural pc/npc register pair. On each advance the pc takes the
// old npc, and the npc takes either the redirect target or npc+4. This
// pairing is what gives MIPS its single branch delay slot.
module mips_cpu_fetch_pcreg
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_advance,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_target,
   output logic [31:0] o_pc,
   output logic [31:0] o_npc
);

   logic [31:0] r_pc;
   logic [31:0] r_npc;
   logic [31:0] w_npc_next;

   // Redirect mux; the +4 path wraps modulo 2^32, so FFFF_FFFC steps to 0.
   always_comb begin
      w_npc_next = r_npc + INSTR_BYTES;
      if (i_redirect_valid) begin
         w_npc_next = i_redirect_target;
      end
   end

   // The pc/npc pair shifts forward only on an enabled commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc  <= RESET_VECTOR;
         r_npc <= RESET_VECTOR + INSTR_BYTES;
      end else if (i_advance) begin
         r_pc  <= r_npc;
         r_npc <= w_npc_next;
      end
   end

   assign o_pc  = r_pc;
   assign o_npc = r_npc;

endmodule

// File: rtl/mips_cpu_fetch_ctrl.sv
// Instruction-fetch sequencer. Fetches one word per instruction from the
// instruction bus (wait-request handshake), presents it to decode for a
// single commit cycle and steps pc/npc with delay-slot semantics. Control
// transfer to address 0, or a misaligned redirect, halts the core.
module mips_cpu_fetch_ctrl
   import mips_cpu_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        instr_read,
   output logic [31:0] instr_address,
   input  logic        instr_waitrequest,
   input  logic [31:0] instr_readdata,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] instr_out,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic        active,
   output logic        fetch_err
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;

   logic [31:0] r_instr;
   logic        r_fetch_err;

   logic        w_accept;
   logic        w_commit;
   logic        w_advance;
   logic        w_misaligned;
   logic [31:0] w_pc;
   logic [31:0] w_npc;

   assign w_accept  = (r_state == ST_FETCH) && !instr_waitrequest;
   assign w_commit  = (r_state == ST_EXEC) && !stall;
   // Once a misaligned redirect has been seen, the delay slot commits
   // without moving pc, so the halted core keeps pointing at the slot.
   assign w_advance = w_commit && !r_fetch_err;
   assign w_misaligned = w_advance && redirect_valid &&
                         !is_word_aligned(redirect_target);

   mips_cpu_fetch_pcreg #(
      .RESET_VECTOR (RESET_VECTOR)
   ) u_pcreg (
      .clk               (clk),
      .rst_n             (rst_n),
      .i_advance         (w_advance),
      .i_redirect_valid  (redirect_valid),
      .i_redirect_target (redirect_target),
      .o_pc              (w_pc),
      .o_npc             (w_npc)
   );

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic. The post-commit pc is the current npc, so the halt
   // decision looks at npc before the pair shifts.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            w_state_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (!instr_waitrequest) begin
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               if (r_fetch_err || (w_npc == HALT_ADDR)) begin
                  w_state_next = ST_HALT;
               end else begin
                  w_state_next = ST_FETCH;
               end
            end
         end
         ST_HALT: begin
            w_state_next = ST_HALT;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Capture the instruction word on the accepting edge of the fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr <= '0;
      end else if (w_accept) begin
         r_instr <= instr_readdata;
      end
   end

   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fetch_err <= 1'b0;
      end else if (w_misaligned) begin
         r_fetch_err <= 1'b1;
      end
   end

   // Outputs come from registers or are decoded from state only.
   assign instr_read    = (r_state == ST_FETCH);
   assign instr_valid   = (r_state == ST_EXEC);
   assign active        = (r_state == ST_FETCH) || (r_state == ST_EXEC);
   assign instr_address = w_pc;
   assign pc_out        = w_pc;
   assign instr_out     = r_instr;
   assign fetch_err     = r_fetch_err;

endmodule

// File: tb/tb_mips_cpu_fetch_ctrl.sv
// Testbench for mips_cpu_fetch_ctrl: directed scenarios plus randomized
// wait/stall/branch traffic, checked against a pc/npc delay-slot model.
module tb_mips_cpu_fetch_ctrl;

   localparam logic [31:0] RV = 32'hBFC0_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_read;
   logic [31:0] instr_address;
   logic        instr_waitrequest = 1'b0;
   logic [31:0] instr_readdata = '0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = '0;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic        active;
   logic        fetch_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_instr  = 0;

   // reference model: architectural pc/npc, error flag, halted flag
   logic [31:0] m_pc;
   logic [31:0] m_npc;
   logic        m_err;
   logic        m_halted;

   mips_cpu_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instr_read        (instr_read),
      .instr_address     (instr_address),
      .instr_waitrequest (instr_waitrequest),
      .instr_readdata    (instr_readdata),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .instr_out         (instr_out),
      .instr_valid       (instr_valid),
      .pc_out            (pc_out),
      .active            (active),
      .fetch_err         (fetch_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // Architectural effect of one commit, straight from the ISA rules.
   task automatic model_commit(input logic redir, input logic [31:0] tgt);
      if (m_err) begin
         m_halted = 1'b1;
      end else begin
         m_pc = m_npc;
         if (redir) begin
            if (tgt[1:0] != 2'b00) m_err = 1'b1;
            m_npc = tgt;
         end else begin
            m_npc = m_npc + 32'd4;
         end
         if (m_pc == 32'd0) m_halted = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      instr_waitrequest = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_read",   32'(instr_read),  32'd0);
      check("rst_valid",  32'(instr_valid), 32'd0);
      check("rst_active", 32'(active),      32'd0);
      check("rst_instr",  instr_out,        32'd0);
      check("rst_err",    32'(fetch_err),   32'd0);
      check("rst_pc",     pc_out,           RV);
      rst_n = 1'b1;
      m_pc = RV;
      m_npc = RV + 32'd4;
      m_err = 1'b0;
      m_halted = 1'b0;
      // this cycle is IDLE; the next one is the first FETCH
      check("idle_active", 32'(active), 32'd0);
      @(negedge clk);
   endtask

   // One instruction: entered at the negedge of its first FETCH cycle.
   task automatic do_instr(input int nwait, input int nstall, input logic redir,
                           input logic [31:0] tgt);
      logic [31:0] data;
      check("fetch_read",   32'(instr_read),  32'd1);
      check("fetch_valid",  32'(instr_valid), 32'd0);
      check("fetch_active", 32'(active),      32'd1);
      check("fetch_addr",   instr_address,    m_pc);
      for (int w = 0; w < nwait; w++) begin
         instr_waitrequest = 1'b1;
         instr_readdata = $urandom;
         stall = 1'($urandom);
         redirect_valid = 1'($urandom);
         redirect_target = $urandom;
         @(negedge clk);
         check("wait_read",  32'(instr_read),  32'd1);
         check("wait_addr",  instr_address,    m_pc);
         check("wait_valid", 32'(instr_valid), 32'd0);
      end
      data = $urandom;
      instr_waitrequest = 1'b0;
      instr_readdata = data;
      stall = 1'($urandom);
      redirect_valid = 1'($urandom);
      redirect_target = $urandom;
      @(negedge clk);
      instr_readdata = $urandom;
      instr_waitrequest = 1'($urandom);
      check("exec_valid", 32'(instr_valid), 32'd1);
      check("exec_read",  32'(instr_read),  32'd0);
      check("exec_instr", instr_out,        data);
      check("exec_pc",    pc_out,           m_pc);
      for (int s = 0; s < nstall; s++) begin
         stall = 1'b1;
         redirect_valid = 1'($urandom);
         redirect_target = $urandom;
         @(negedge clk);
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_read",  32'(instr_read),  32'd0);
         check("stall_instr", instr_out,        data);
         check("stall_pc",    pc_out,           m_pc);
      end
      stall = 1'b0;
      redirect_valid = redir;
      redirect_target = tgt;
      @(negedge clk);
      redirect_valid = 1'b0;
      instr_waitrequest = 1'b0;
      $display("instr %0d pc=%08h data=%08h wait=%0d stall=%0d redir=%0b tgt=%08h",
               n_instr, m_pc, data, nwait, nstall, redir, tgt);
      n_instr++;
      model_commit(redir, tgt);
      check("commit_err", 32'(fetch_err), 32'(m_err));
      if (m_halted) check("halt_pc", pc_out, m_pc);
   endtask

   task automatic check_halted(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         check("halt_read",   32'(instr_read),  32'd0);
         check("halt_valid",  32'(instr_valid), 32'd0);
         check("halt_active", 32'(active),      32'd0);
         check("halt_pcout",  pc_out,           m_pc);
         check("halt_err",    32'(fetch_err),   32'(m_err));
         instr_waitrequest = 1'($urandom);
         stall = 1'($urandom);
         redirect_valid = 1'($urandom);
         redirect_target = $urandom;
         @(negedge clk);
      end
      instr_waitrequest = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
   endtask

   initial begin
      // sequential fetch, taken branch with delay slot, long stall
      do_reset();
      do_instr(0, 0, 1'b0, 32'd0);
      do_instr(0, 0, 1'b0, 32'd0);
      do_instr(0, 0, 1'b1, 32'hBFC0_0100);
      check("ds_addr", instr_address, 32'hBFC0_000C);
      do_instr(0, 0, 1'b0, 32'd0);
      check("tgt_addr", instr_address, 32'hBFC0_0100);
      do_instr(0, 5, 1'b0, 32'd0);

      // randomized traffic, branches into the boot region (never address 0)
      for (int i = 0; i < 40 && !m_halted; i++) begin
         do_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  ($urandom_range(0, 3) == 0),
                  RV + (32'($urandom_range(0, 1023)) << 2));
      end

      // first fetch with 3 wait cycles, then jr to 0 at BFC00010
      do_reset();
      do_instr(3, 0, 1'b0, 32'd0);
      do_instr(0, 0, 1'b0, 32'd0);
      do_instr(0, 0, 1'b0, 32'd0);
      do_instr(0, 0, 1'b0, 32'd0);
      check("jr_addr", instr_address, 32'hBFC0_0010);
      do_instr(0, 0, 1'b1, 32'd0);
      check("jr_ds_addr", instr_address, 32'hBFC0_0014);
      do_instr(0, 0, 1'b0, 32'd0);
      check_halted(20);
      check("jr_halt_pc", pc_out, 32'd0);

      // misaligned redirect: delay slot commits, then halt at the slot pc
      do_reset();
      do_instr(0, 0, 1'b0, 32'd0);
      do_instr(1, 1, 1'b1, 32'hBFC0_0102);
      do_instr(0, 0, 1'b0, 32'd0);
      check_halted(5);
      check("mis_halt_pc", pc_out, 32'hBFC0_0008);
      check("mis_err", 32'(fetch_err), 32'd1);

      // reset in the middle of a held fetch
      do_reset();
      instr_waitrequest = 1'b1;
      @(negedge clk);
      check("mid_read", 32'(instr_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_drop", 32'(instr_read), 32'd0);
      check("async_active", 32'(active), 32'd0);
      do_reset();
      check("restart_addr", instr_address, RV);
      do_instr(0, 0, 1'b0, 32'd0);

      // address wrap: FFFFFFFC + 4 is 0, which halts
      do_reset();
      do_instr(0, 0, 1'b1, 32'hFFFF_FFF8);
      for (int i = 0; i < 6 && !m_halted; i++) begin
         do_instr(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'b0, 32'd0);
      end
      check_halted(3);
      check("wrap_halt_pc", pc_out, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
